// File: rtl/btn_evt_pkg.sv
// ============================================================================
//  Module      : btn_evt_pkg
//  Description : Shared types for the button event pipeline. These are the
//                FSM state encoding, the event codes seen by the core, and a
//                small helper for sizing the counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package btn_evt_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } btn_state_t;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_LONG    = 2'd2,
        EVT_REPEAT  = 2'd3
    } evt_code_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_evt_slot.sv
// ============================================================================
//  Module      : btn_evt_slot
//  Description : Single-entry valid/ready event holding register with a
//                sticky overrun flag. Any new event that arrives while the
//                slot is full and not being drained is dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module btn_evt_slot
    import btn_evt_pkg::*;
(
    input  logic      clk,
    input  logic      nReset,
    input  logic      raise,
    input  evt_code_t code,
    input  logic      evt_ready,
    input  logic      overrun_clr,
    output logic      evt_valid,
    output evt_code_t evt_code,
    output logic      overrun
);

    logic      valid_q, valid_d;
    evt_code_t code_q,  code_d;
    logic      ovr_q,   ovr_d;

    // Slot load/drain and overrun. A drop sets overrun after the clear is applied, so a drop wins over a clear.
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        ovr_d   = ovr_q;

        if (overrun_clr) begin
            ovr_d = 1'b0;
        end

        if (raise) begin
            if (!valid_q || evt_ready) begin
                valid_d = 1'b1;
                code_d  = code;
            end else begin
                ovr_d   = 1'b1;
            end
        end else if (valid_q && evt_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot state registers.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            valid_q <= 1'b0;
            code_q  <= EVT_PRESS;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            code_q  <= code_d;
            ovr_q   <= ovr_d;
        end
    end

    assign evt_valid = valid_q;
    assign evt_code  = code_q;
    assign overrun   = ovr_q;

endmodule

`default_nettype wire

// File: rtl/button_events.sv
// ============================================================================
//  Module      : button_events
//  Description : Turns a debounced button level into PRESS / RELEASE / LONG /
//                REPEAT events. Each event is handed to the register block
//                through a single-entry valid/ready slot.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module button_events
    import btn_evt_pkg::*;
#(
    parameter int LONG_CYCLES   = 50,   // must be >= 2
    parameter int REPEAT_CYCLES = 20    // must be >= 2
)(
    input  logic       clk,
    input  logic       nReset,
    input  logic       in,
    input  logic       evt_ready,
    input  logic       overrun_clr,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    output logic       held,
    output logic       overrun
);

    localparam int MAX_CYCLES = max_int(LONG_CYCLES, REPEAT_CYCLES);
    localparam int CNT_W      = $clog2(MAX_CYCLES);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             held_q,  held_d;
    logic             raise;
    evt_code_t        code;
    evt_code_t        slot_code;

    // Next state, hold counter and the single event raised at this edge. The counter is compared before it
    // increments, so LONG lands exactly LONG_CYCLES edges after PRESS.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        raise   = 1'b0;
        code    = EVT_PRESS;

        case (state_q)
            IDLE: begin
                if (in) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    raise   = 1'b1;
                    code    = EVT_PRESS;
                end
            end
            PRESSED: begin
                if (!in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    raise   = 1'b1;
                    code    = EVT_RELEASE;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG_HELD;
                    cnt_d   = '0;
                    raise   = 1'b1;
                    code    = EVT_LONG;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            LONG_HELD: begin
                if (!in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    raise   = 1'b1;
                    code    = EVT_RELEASE;
                end else if (cnt_q == REPEAT_LAST) begin
                    cnt_d   = '0;
                    raise   = 1'b1;
                    code    = EVT_REPEAT;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d != IDLE);
    end

    // FSM, counter and held registers.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
        end
    end

    btn_evt_slot u_slot (
        .clk         (clk),
        .nReset      (nReset),
        .raise       (raise),
        .code        (code),
        .evt_ready   (evt_ready),
        .overrun_clr (overrun_clr),
        .evt_valid   (evt_valid),
        .evt_code    (slot_code),
        .overrun     (overrun)
    );

    assign evt_code = slot_code;
    assign held     = held_q;

endmodule

`default_nettype wire

// File: tb/tb_button_events.sv
// ============================================================================
//  Module      : tb_button_events
//  Description : Directed self-checking bench for button_events using the
//                default parameters (LONG 50, REPEAT 20).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_button_events;

    logic       clk;
    logic       nReset;
    logic       btn_in;
    logic       evt_ready;
    logic       overrun_clr;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       held;
    logic       overrun;

    int n_checks = 0;
    int n_pass   = 0;

    button_events dut (
        .clk         (clk),
        .nReset      (nReset),
        .in          (btn_in),
        .evt_ready   (evt_ready),
        .overrun_clr (overrun_clr),
        .evt_valid   (evt_valid),
        .evt_code    (evt_code),
        .held        (held),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_slot(input string tag, input logic v, input logic [1:0] c, input logic o);
        chk({tag, ".valid"},   32'(evt_valid), 32'(v));
        chk({tag, ".code"},    32'(evt_code),  32'(c));
        chk({tag, ".overrun"}, 32'(overrun),   32'(o));
    endtask

    int        ev_cnt;
    int        ev_idx [8];
    logic [1:0] ev_code[8];
    logic      held_all;
    int        long_at;

    initial begin
        nReset      = 1'b0;
        btn_in      = 1'b0;
        evt_ready   = 1'b0;
        overrun_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk_slot("reset", 1'b0, 2'd0, 1'b0);
        chk("reset.held", 32'(held), 32'd0);
        nReset = 1'b1;
        @(negedge clk);

        // 1: short press, consumer always ready
        evt_ready = 1'b1;
        btn_in    = 1'b1;
        @(negedge clk);
        chk_slot("t1.press", 1'b1, 2'd0, 1'b0);
        chk("t1.held", 32'(held), 32'd1);
        @(negedge clk);
        chk("t1.drain", 32'(evt_valid), 32'd0);
        repeat (8) @(negedge clk);
        chk("t1.nolong", 32'(evt_valid), 32'd0);
        btn_in = 1'b0;
        @(negedge clk);
        chk_slot("t1.release", 1'b1, 2'd1, 1'b0);
        chk("t1.held_off", 32'(held), 32'd0);
        @(negedge clk);
        chk("t1.idle", 32'(evt_valid), 32'd0);

        // 2: 100-cycle hold, log every event by edge offset from the press
        btn_in   = 1'b1;
        ev_cnt   = 0;
        held_all = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!held) held_all = 1'b0;
            if (evt_valid === 1'b1) begin
                if (ev_cnt < 8) begin
                    ev_idx[ev_cnt]  = i;
                    ev_code[ev_cnt] = evt_code;
                end
                ev_cnt++;
            end
        end
        chk("t2.count", 32'(ev_cnt), 32'd4);
        chk("t2.held_all", 32'(held_all), 32'd1);
        chk("t2.ev0.at", 32'(ev_idx[0]), 32'd0);
        chk("t2.ev0.code", 32'(ev_code[0]), 32'd0);
        chk("t2.ev1.at", 32'(ev_idx[1]), 32'd50);
        chk("t2.ev1.code", 32'(ev_code[1]), 32'd2);
        chk("t2.ev2.at", 32'(ev_idx[2]), 32'd70);
        chk("t2.ev2.code", 32'(ev_code[2]), 32'd3);
        chk("t2.ev3.at", 32'(ev_idx[3]), 32'd90);
        chk("t2.ev3.code", 32'(ev_code[3]), 32'd3);
        btn_in = 1'b0;
        @(negedge clk);
        chk_slot("t2.release", 1'b1, 2'd1, 1'b0);
        @(negedge clk);
        chk("t2.idle", 32'(evt_valid), 32'd0);

        // 3: consumer stalled, release is dropped
        evt_ready = 1'b0;
        btn_in    = 1'b1;
        @(negedge clk);
        chk_slot("t3.press", 1'b1, 2'd0, 1'b0);
        btn_in = 1'b0;
        @(negedge clk);
        chk_slot("t3.drop", 1'b1, 2'd0, 1'b1);
        evt_ready = 1'b1;
        @(negedge clk);
        chk_slot("t3.drain", 1'b0, 2'd0, 1'b1);
        evt_ready   = 1'b0;
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk("t3.clr", 32'(overrun), 32'd0);

        // 4: same-edge handshake + new event, then drop vs clear
        btn_in = 1'b1;
        @(negedge clk);
        chk_slot("t4.press", 1'b1, 2'd0, 1'b0);
        evt_ready = 1'b1;
        btn_in    = 1'b0;
        @(negedge clk);
        chk_slot("t4.swap", 1'b1, 2'd1, 1'b0);
        evt_ready   = 1'b0;
        btn_in      = 1'b1;
        overrun_clr = 1'b1;
        @(negedge clk);
        chk_slot("t4.setwins", 1'b1, 2'd1, 1'b1);
        evt_ready = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk_slot("t4.cleanup", 1'b0, 2'd1, 1'b0);
        btn_in = 1'b0;
        @(negedge clk);
        chk_slot("t4.release", 1'b1, 2'd1, 1'b0);
        @(negedge clk);

        // 5: reset in the middle of a hold
        btn_in = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 50) chk_slot("t5.long", 1'b1, 2'd2, 1'b0);
        end
        nReset = 1'b0;
        #1;
        chk_slot("t5.rst_async", 1'b0, 2'd0, 1'b0);
        chk("t5.rst_held", 32'(held), 32'd0);
        repeat (2) @(negedge clk);
        chk_slot("t5.rst_hold", 1'b0, 2'd0, 1'b0);
        nReset = 1'b1;
        @(negedge clk);
        chk_slot("t5.fresh_press", 1'b1, 2'd0, 1'b0);
        chk("t5.held", 32'(held), 32'd1);
        ev_cnt  = 0;
        long_at = -1;
        for (int i = 1; i <= 55; i++) begin
            @(negedge clk);
            if (evt_valid === 1'b1) begin
                ev_cnt++;
                if (evt_code === 2'd2 && long_at < 0) long_at = i;
            end
        end
        chk("t5.long_at", 32'(long_at), 32'd50);
        chk("t5.events", 32'(ev_cnt), 32'd1);
        btn_in = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
